// File: rtl/gr_wb_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module   : gr_wb_scoreboard_if
//  Purpose  : Issue, writeback and register-file write bundle for the
//             general-register scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
interface gr_wb_scoreboard_if #(
    parameter int XLEN = 32
);
    // Issue side (decode -> scoreboard)
    logic            iss_valid;
    logic            iss_rs1;
    logic [4:0]      iss_rs1_n;
    logic            iss_rs2;
    logic [4:0]      iss_rs2_n;
    logic            iss_rd;
    logic [4:0]      iss_rd_n;
    logic            iss_ready;
    // ALU writeback
    logic            alu_wb_valid;
    logic [4:0]      alu_wb_rd_n;
    logic [XLEN-1:0] alu_wb_wd;
    logic            alu_wb_ready;
    // LSU writeback
    logic            lsu_wb_valid;
    logic [4:0]      lsu_wb_rd_n;
    logic [XLEN-1:0] lsu_wb_wd;
    logic            lsu_wb_ready;
    // Register-file write port and status
    logic            gr_rd;
    logic [4:0]      gr_rd_n;
    logic [XLEN-1:0] gr_wd;
    logic [5:0]      busy_cnt;

    modport master (
        output iss_valid, iss_rs1, iss_rs1_n, iss_rs2, iss_rs2_n, iss_rd, iss_rd_n,
        output alu_wb_valid, alu_wb_rd_n, alu_wb_wd,
        output lsu_wb_valid, lsu_wb_rd_n, lsu_wb_wd,
        input  iss_ready, alu_wb_ready, lsu_wb_ready,
        input  gr_rd, gr_rd_n, gr_wd, busy_cnt
    );

    modport slave (
        input  iss_valid, iss_rs1, iss_rs1_n, iss_rs2, iss_rs2_n, iss_rd, iss_rd_n,
        input  alu_wb_valid, alu_wb_rd_n, alu_wb_wd,
        input  lsu_wb_valid, lsu_wb_rd_n, lsu_wb_wd,
        output iss_ready, alu_wb_ready, lsu_wb_ready,
        output gr_rd, gr_rd_n, gr_wd, busy_cnt
    );
endinterface
`default_nettype wire

// File: rtl/gr_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : gr_wb_scoreboard
//  Purpose  : Busy scoreboard for the 32x32 GR file with RAW/WAW issue stall
//             and round-robin ALU/LSU arbitration of the single write port.
//  Revision : 1.0  initial release
// ============================================================================
module gr_wb_scoreboard #(
    parameter int XLEN    = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  wire logic          m_clock,
    input  wire logic          rst_n,
    input  wire logic          flush,
    gr_wb_scoreboard_if.slave  bus
);

    // x0 is never tracked, so only bits 31:1 are stored.
    logic [31:1] busy_q;
    logic [31:0] busy;
    logic [31:0] busy_v;
    logic [5:0]  cnt_nxt;
    logic        prio;          // 0: ALU wins a contest, 1: LSU wins
    logic        issue_fire;
    logic        grant_alu;
    logic        grant_lsu;
    logic        contested;

    assign busy = {busy_q, 1'b0};

    // Hazard check: any source or destination operand that is still busy stalls issue.
    always_comb begin
        bus.iss_ready = ~flush
                      & ~(bus.iss_rs1 & busy[bus.iss_rs1_n])
                      & ~(bus.iss_rs2 & busy[bus.iss_rs2_n])
                      & ~(bus.iss_rd  & busy[bus.iss_rd_n]);
        issue_fire    = bus.iss_valid & bus.iss_ready;
    end

    // Write-port arbitration; a lone requester always wins, a contest goes to prio.
    always_comb begin
        grant_alu = ~flush & bus.alu_wb_valid & (~bus.lsu_wb_valid | ~prio);
        grant_lsu = ~flush & bus.lsu_wb_valid & (~bus.alu_wb_valid |  prio);
        contested = (grant_alu & bus.lsu_wb_valid) | (grant_lsu & bus.alu_wb_valid);
        bus.alu_wb_ready = grant_alu;
        bus.lsu_wb_ready = grant_lsu;
    end

    // Next busy vector: clear from the write now on the GR port, then set from issue
    // (set wins on a collision), and a flush wipes everything.
    always_comb begin
        busy_v = busy;
        if (bus.gr_rd) begin
            busy_v[bus.gr_rd_n] = 1'b0;
        end
        if (issue_fire && bus.iss_rd) begin
            busy_v[bus.iss_rd_n] = 1'b1;
        end
        if (flush) begin
            busy_v = '0;
        end
        busy_v[0] = 1'b0;
        cnt_nxt = 6'd0;
        for (int i = 1; i < 32; i++) begin
            cnt_nxt = cnt_nxt + {5'd0, busy_v[i]};
        end
    end

    // State registers: scoreboard, priority token and the registered GR write port.
    always_ff @(posedge m_clock or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            prio         <= RR_INIT;
            bus.gr_rd    <= 1'b0;
            bus.gr_rd_n  <= 5'd0;
            bus.gr_wd    <= '0;
            bus.busy_cnt <= 6'd0;
        end else begin
            busy_q       <= busy_v[31:1];
            bus.busy_cnt <= cnt_nxt;
            if (contested) begin
                prio <= ~prio;
            end
            // A granted write to x0 is acknowledged but never strobed.
            bus.gr_rd <= (grant_alu & (bus.alu_wb_rd_n != 5'd0))
                       | (grant_lsu & (bus.lsu_wb_rd_n != 5'd0));
            if (grant_alu) begin
                bus.gr_rd_n <= bus.alu_wb_rd_n;
                bus.gr_wd   <= bus.alu_wb_wd;
            end else if (grant_lsu) begin
                bus.gr_rd_n <= bus.lsu_wb_rd_n;
                bus.gr_wd   <= bus.lsu_wb_wd;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gr_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gr_wb_scoreboard
//  Purpose  : Self-checking bench for gr_wb_scoreboard: vector table, directed
//             multi-cycle sequences and randomized traffic against a model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gr_wb_scoreboard;

    logic m_clock;
    logic rst_n;
    logic flush;
    int   errors = 0;
    int   checks = 0;

    gr_wb_scoreboard_if #(.XLEN(32)) bus ();

    gr_wb_scoreboard #(.XLEN(32), .RR_INIT(1'b0)) dut (
        .m_clock (m_clock),
        .rst_n   (rst_n),
        .flush   (flush),
        .bus     (bus.slave)
    );

    initial begin
        m_clock = 1'b0;
        forever #5 m_clock = ~m_clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;  logic r1; logic [4:0] r1n; logic rd; logic [4:0] rdn;
        logic        av;  logic [4:0] an; logic [31:0] ad;
        logic        lv;  logic [4:0] ln; logic [31:0] ld;
        logic        fl;
        logic        e_rdy; logic e_a; logic e_l; logic e_grd; logic [4:0] e_grdn;
        logic [31:0] e_wd;  logic [5:0] e_cnt;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.iss_valid = 0; bus.iss_rs1 = 0; bus.iss_rs1_n = 0; bus.iss_rs2 = 0;
        bus.iss_rs2_n = 0; bus.iss_rd = 0; bus.iss_rd_n = 0;
        bus.alu_wb_valid = 0; bus.alu_wb_rd_n = 0; bus.alu_wb_wd = 0;
        bus.lsu_wb_valid = 0; bus.lsu_wb_rd_n = 0; bus.lsu_wb_wd = 0;
        flush = 0;
    endtask

    task automatic next_cycle();
        @(posedge m_clock);
        #1;
    endtask

    // Reset with the reset-state checks; returns at posedge+1 with reset released.
    task automatic reset_dut(input string tag);
        idle();
        rst_n = 1'b0;
        next_cycle();
        next_cycle();
        chk({tag, " reset gr_rd"},    32'(bus.gr_rd),    32'd0);
        chk({tag, " reset gr_rd_n"},  32'(bus.gr_rd_n),  32'd0);
        chk({tag, " reset gr_wd"},    bus.gr_wd,         32'd0);
        chk({tag, " reset busy_cnt"}, 32'(bus.busy_cnt), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic issue(input logic r1, input logic [4:0] r1n, input logic rd, input logic [4:0] rdn);
        bus.iss_valid = 1; bus.iss_rs1 = r1; bus.iss_rs1_n = r1n;
        bus.iss_rd = rd; bus.iss_rd_n = rdn;
    endtask

    task automatic alu(input logic v, input logic [4:0] n, input logic [31:0] d);
        bus.alu_wb_valid = v; bus.alu_wb_rd_n = n; bus.alu_wb_wd = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] n, input logic [31:0] d);
        bus.lsu_wb_valid = v; bus.lsu_wb_rd_n = n; bus.lsu_wb_wd = d;
    endtask

    // Reference model state for the randomized phase.
    bit          m_busy [32];
    bit          m_prio;
    bit          m_grd;
    logic [4:0]  m_grdn;
    logic [31:0] m_gwd;
    int          m_cnt;

    initial begin
        rst_n = 1'b0;
        idle();

        // Columns: iv r1 r1n rd rdn | av an ad | lv ln ld | fl || rdy a l grd grdn wd cnt
        vecs[0]  = '{1,0,0,1,5, 0,0,0,            0,0,0, 0, 1,0,0,0,0,0,           0};
        vecs[1]  = '{0,0,0,0,0, 0,0,0,            0,0,0, 0, 1,0,0,0,0,0,           1};
        vecs[2]  = '{0,0,0,0,0, 0,0,0,            0,0,0, 0, 1,0,0,0,0,0,           1};
        vecs[3]  = '{0,1,5,0,0, 1,5,32'hDEADBEEF, 0,0,0, 0, 0,1,0,0,0,0,           1};
        vecs[4]  = '{0,1,5,0,0, 0,0,0,            0,0,0, 0, 0,0,0,1,5,32'hDEADBEEF,1};
        vecs[5]  = '{0,1,5,0,0, 0,0,0,            0,0,0, 0, 1,0,0,0,0,0,           0};
        vecs[6]  = '{0,0,0,0,0, 1,7,1,            1,9,2, 0, 1,1,0,0,0,0,           0};
        vecs[7]  = '{0,0,0,0,0, 1,7,1,            1,9,2, 0, 1,0,1,1,7,1,           0};
        vecs[8]  = '{0,0,0,0,0, 1,7,1,            1,9,2, 0, 1,1,0,1,9,2,           0};
        vecs[9]  = '{0,0,0,0,0, 0,0,0,            0,0,0, 0, 1,0,0,1,7,1,           0};
        vecs[10] = '{0,0,0,0,0, 0,0,0,            0,0,0, 0, 1,0,0,0,0,0,           0};
        vecs[11] = '{1,0,0,1,0, 0,0,0,            0,0,0, 0, 1,0,0,0,0,0,           0};
        vecs[12] = '{0,0,0,0,0, 1,0,32'h55,       0,0,0, 0, 1,1,0,0,0,0,           0};
        vecs[13] = '{0,0,0,0,0, 0,0,0,            0,0,0, 0, 1,0,0,0,0,0,           0};

        // ---------------- table-driven vectors ----------------
        reset_dut("tbl");
        for (int i = 0; i < 14; i++) begin
            idle();
            issue(vecs[i].r1, vecs[i].r1n, vecs[i].rd, vecs[i].rdn);
            bus.iss_valid = vecs[i].iv;
            alu(vecs[i].av, vecs[i].an, vecs[i].ad);
            lsu(vecs[i].lv, vecs[i].ln, vecs[i].ld);
            flush = vecs[i].fl;
            @(negedge m_clock);
            chk($sformatf("vec%0d iss_ready", i),    32'(bus.iss_ready),    32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d alu_wb_ready", i), 32'(bus.alu_wb_ready), 32'(vecs[i].e_a));
            chk($sformatf("vec%0d lsu_wb_ready", i), 32'(bus.lsu_wb_ready), 32'(vecs[i].e_l));
            chk($sformatf("vec%0d gr_rd", i),        32'(bus.gr_rd),        32'(vecs[i].e_grd));
            chk($sformatf("vec%0d busy_cnt", i),     32'(bus.busy_cnt),     32'(vecs[i].e_cnt));
            if (vecs[i].e_grd) begin
                chk($sformatf("vec%0d gr_rd_n", i), 32'(bus.gr_rd_n), 32'(vecs[i].e_grdn));
                chk($sformatf("vec%0d gr_wd", i),   bus.gr_wd,        vecs[i].e_wd);
            end
            next_cycle();
        end

        // ---------------- RAW stall until the cycle after the write pulse ----------------
        reset_dut("raw");
        idle(); issue(0, 0, 1, 3);
        @(negedge m_clock); chk("raw c0 ready", 32'(bus.iss_ready), 32'd1);
        next_cycle();
        idle(); issue(1, 3, 0, 0);
        @(negedge m_clock); chk("raw c1 ready", 32'(bus.iss_ready), 32'd0);
        next_cycle();
        alu(1, 3, 32'h0000_0333);
        @(negedge m_clock); chk("raw c2 ready", 32'(bus.iss_ready), 32'd0);
        chk("raw c2 alu_ready", 32'(bus.alu_wb_ready), 32'd1);
        next_cycle();
        alu(0, 0, 0);
        @(negedge m_clock); chk("raw c3 ready", 32'(bus.iss_ready), 32'd0);
        chk("raw c3 gr_rd", 32'(bus.gr_rd), 32'd1);
        chk("raw c3 gr_rd_n", 32'(bus.gr_rd_n), 32'd3);
        next_cycle();
        @(negedge m_clock); chk("raw c4 ready", 32'(bus.iss_ready), 32'd1);
        chk("raw c4 gr_rd", 32'(bus.gr_rd), 32'd0);
        next_cycle();

        // ---------------- flush with busy registers and a pending ALU write ----------------
        reset_dut("fl");
        idle(); issue(0, 0, 1, 1); next_cycle();
        idle(); issue(0, 0, 1, 2); next_cycle();
        idle(); issue(0, 0, 1, 4); next_cycle();
        idle(); alu(1, 1, 32'h7); flush = 1;
        @(negedge m_clock);
        chk("fl busy_cnt before", 32'(bus.busy_cnt), 32'd3);
        chk("fl alu_ready", 32'(bus.alu_wb_ready), 32'd0);
        chk("fl iss_ready", 32'(bus.iss_ready), 32'd0);
        next_cycle();
        idle(); issue(1, 1, 0, 0); bus.iss_valid = 0;
        @(negedge m_clock);
        chk("fl busy_cnt after", 32'(bus.busy_cnt), 32'd0);
        chk("fl gr_rd", 32'(bus.gr_rd), 32'd0);
        chk("fl ready after", 32'(bus.iss_ready), 32'd1);
        next_cycle();

        // ---------------- async reset between grant and its write cycle ----------------
        reset_dut("rst");
        idle(); issue(0, 0, 1, 6); next_cycle();
        idle(); alu(1, 8, 32'h88); lsu(1, 10, 32'hAA);
        @(negedge m_clock);
        chk("rst contest alu", 32'(bus.alu_wb_ready), 32'd1);
        chk("rst busy_cnt pre", 32'(bus.busy_cnt), 32'd1);
        next_cycle();
        chk("rst gr_rd pre", 32'(bus.gr_rd), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst gr_rd async", 32'(bus.gr_rd), 32'd0);
        chk("rst busy_cnt async", 32'(bus.busy_cnt), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge m_clock);
        chk("rst prio alu", 32'(bus.alu_wb_ready), 32'd1);
        chk("rst prio lsu", 32'(bus.lsu_wb_ready), 32'd0);
        next_cycle();

        // ---------------- randomized traffic against the model ----------------
        reset_dut("rnd");
        foreach (m_busy[k]) m_busy[k] = 0;
        m_prio = 0; m_grd = 0; m_grdn = 0; m_gwd = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit e_rdy, e_a, e_l;
            bus.iss_valid   = 1'($urandom_range(0, 1));
            bus.iss_rs1     = 1'($urandom_range(0, 1));
            bus.iss_rs1_n   = 5'($urandom_range(0, 7));
            bus.iss_rs2     = 1'($urandom_range(0, 1));
            bus.iss_rs2_n   = 5'($urandom_range(0, 7));
            bus.iss_rd      = 1'($urandom_range(0, 1));
            bus.iss_rd_n    = 5'($urandom_range(0, 7));
            alu(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
            lsu(1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom);
            flush = 1'($urandom_range(0, 19) == 0);
            @(negedge m_clock);

            e_rdy = !flush && !(bus.iss_rs1 && m_busy[bus.iss_rs1_n])
                           && !(bus.iss_rs2 && m_busy[bus.iss_rs2_n])
                           && !(bus.iss_rd  && m_busy[bus.iss_rd_n]);
            e_a = !flush && bus.alu_wb_valid && (!bus.lsu_wb_valid || m_prio == 0);
            e_l = !flush && bus.lsu_wb_valid && (!bus.alu_wb_valid || m_prio == 1);
            chk($sformatf("rnd%0d iss_ready", cyc),    32'(bus.iss_ready),    32'(e_rdy));
            chk($sformatf("rnd%0d alu_wb_ready", cyc), 32'(bus.alu_wb_ready), 32'(e_a));
            chk($sformatf("rnd%0d lsu_wb_ready", cyc), 32'(bus.lsu_wb_ready), 32'(e_l));
            chk($sformatf("rnd%0d gr_rd", cyc),        32'(bus.gr_rd),        32'(m_grd));
            chk($sformatf("rnd%0d busy_cnt", cyc),     32'(bus.busy_cnt),     32'(m_cnt));
            if (m_grd) begin
                chk($sformatf("rnd%0d gr_rd_n", cyc), 32'(bus.gr_rd_n), 32'(m_grdn));
                chk($sformatf("rnd%0d gr_wd", cyc),   bus.gr_wd,        m_gwd);
            end

            // Advance the model by one clock edge.
            if (flush) begin
                foreach (m_busy[k]) m_busy[k] = 0;
            end else begin
                if (m_grd) m_busy[m_grdn] = 0;
                if (bus.iss_valid && e_rdy && bus.iss_rd && bus.iss_rd_n != 0)
                    m_busy[bus.iss_rd_n] = 1;
            end
            m_cnt = 0;
            foreach (m_busy[k]) m_cnt += int'(m_busy[k]);
            if (!flush && bus.alu_wb_valid && bus.lsu_wb_valid) m_prio = !m_prio;
            if (e_a) begin
                m_grd = (bus.alu_wb_rd_n != 0); m_grdn = bus.alu_wb_rd_n; m_gwd = bus.alu_wb_wd;
            end else if (e_l) begin
                m_grd = (bus.lsu_wb_rd_n != 0); m_grdn = bus.lsu_wb_rd_n; m_gwd = bus.lsu_wb_wd;
            end else begin
                m_grd = 0;
            end
            next_cycle();
        end

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
